// File: rtl/sync_dff_pipe_pkg.sv
// rtl/sync_dff_pipe_pkg.sv - shared helpers for the stallable register pipeline
package sync_dff_pipe_pkg;

   // Counter must represent 0..DEPTH inclusive, hence depth+1.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_dff_pipe_dff_stage.sv
// rtl/sync_dff_pipe_dff_stage.sv - one data register plus valid bit with stall and clear
module dff_stage #(
   parameter int                 WIDTH   = 8,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               en,
   input  logic [WIDTH-1:0]   d,
   input  logic               vld_i,
   output logic [WIDTH-1:0]   q,
   output logic               vld_o
);

   logic [WIDTH-1:0] r_data;
   logic             r_vld;

   // Data is captured regardless of vld_i; only the valid bit qualifies it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_data <= RST_VAL;
         r_vld  <= 1'b0;
      end else if (en) begin
         r_data <= d;
         r_vld  <= vld_i;
      end
   end

   assign q     = r_data;
   assign vld_o = r_vld;

endmodule

// File: rtl/sync_dff_pipe.sv
// rtl/sync_dff_pipe.sv - DEPTH-stage stallable delay line with valid tracking and occupancy count
module sync_dff_pipe
   import sync_dff_pipe_pkg::*;
#(
   parameter int                 WIDTH   = 8,
   parameter int                 DEPTH   = 4,
   parameter logic [WIDTH-1:0]   RST_VAL = '0,
   parameter bit                 GATE_Q  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        flush,
   input  logic [WIDTH-1:0]            d,
   input  logic                        vld_i,
   output logic [WIDTH-1:0]            q,
   output logic                        vld_o,
   output logic [cnt_w(DEPTH)-1:0]     cnt
);

   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] w_data [DEPTH];
   logic             w_vld  [DEPTH];
   logic [CW-1:0]    r_cnt;

   genvar k;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_stage
         if (k == 0) begin : g_head
            dff_stage #(
               .WIDTH   (WIDTH),
               .RST_VAL (RST_VAL)
            ) u_stage (
               .clk   (clk),
               .rst   (rst),
               .clr   (flush),
               .en    (en),
               .d     (d),
               .vld_i (vld_i),
               .q     (w_data[k]),
               .vld_o (w_vld[k])
            );
         end else begin : g_body
            dff_stage #(
               .WIDTH   (WIDTH),
               .RST_VAL (RST_VAL)
            ) u_stage (
               .clk   (clk),
               .rst   (rst),
               .clr   (flush),
               .en    (en),
               .d     (w_data[k-1]),
               .vld_i (w_vld[k-1]),
               .q     (w_data[k]),
               .vld_o (w_vld[k])
            );
         end
      end
   endgenerate

   // Incremental occupancy: a word entering and one leaving on the same edge cancel.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + CW'(vld_i) - CW'(w_vld[DEPTH-1]);
      end
   end

   generate
      if (GATE_Q) begin : g_gate
         assign q = w_vld[DEPTH-1] ? w_data[DEPTH-1] : RST_VAL;
      end else begin : g_raw
         assign q = w_data[DEPTH-1];
      end
   endgenerate

   assign vld_o = w_vld[DEPTH-1];
   assign cnt   = r_cnt;

endmodule

// File: tb/tb_sync_dff_pipe.sv
// tb/tb_sync_dff_pipe.sv - directed and randomized checks of sync_dff_pipe
module tb_sync_dff_pipe;

   logic       clk;
   logic       rst, en, flush, vld_i;
   logic [7:0] d;
   logic [7:0] q_g, q_u;
   logic       vo_g, vo_u;
   logic [2:0] cnt_g, cnt_u;

   logic       r1_rst, r1_en, r1_flush, r1_vld_i, r1_d;
   logic       q_1, vo_1;
   logic [0:0] cnt_1;

   int total = 0;
   int bad   = 0;

   logic m_q, m_v;
   logic [0:0] m_cnt;
   logic m_qexp;

   sync_dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5), .GATE_Q(1'b1)) u_gated (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .vld_i(vld_i),
      .q(q_g), .vld_o(vo_g), .cnt(cnt_g));

   sync_dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5), .GATE_Q(1'b0)) u_raw (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .vld_i(vld_i),
      .q(q_u), .vld_o(vo_u), .cnt(cnt_u));

   sync_dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1), .GATE_Q(1'b1)) u_d1 (
      .clk(clk), .rst(r1_rst), .en(r1_en), .flush(r1_flush), .d(r1_d), .vld_i(r1_vld_i),
      .q(q_1), .vld_o(vo_1), .cnt(cnt_1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_g(input string tag, input logic [7:0] eq, input logic ev, input logic [2:0] ec);
      chk({tag, "_q"},   32'(q_g),   32'(eq));
      chk({tag, "_vld"}, 32'(vo_g),  32'(ev));
      chk({tag, "_cnt"}, 32'(cnt_g), 32'(ec));
   endtask

   logic [7:0] bub_qg [4];
   logic [7:0] bub_qu [4];
   logic       bub_v  [4];
   logic [2:0] bub_c  [4];
   logic [2:0] drain_c [4];
   logic [7:0] drain_q [4];

   initial begin
      bub_qg = '{8'h10, 8'hA5, 8'h12, 8'hA5};
      bub_qu = '{8'h10, 8'h11, 8'h12, 8'h13};
      bub_v  = '{1'b1, 1'b0, 1'b1, 1'b0};
      bub_c  = '{3'd2, 3'd1, 3'd1, 3'd0};
      drain_q = '{8'h02, 8'h03, 8'h04, 8'hA5};
      drain_c = '{3'd3, 3'd2, 3'd1, 3'd0};

      rst = 1'b1; en = 1'b0; flush = 1'b0; vld_i = 1'b0; d = 8'h00;
      r1_rst = 1'b1; r1_en = 1'b0; r1_flush = 1'b0; r1_vld_i = 1'b0; r1_d = 1'b0;
      repeat (3) step();
      chk_g("reset", 8'hA5, 1'b0, 3'd0);
      chk("reset_raw_q", 32'(q_u), 32'hA5);

      // fill 01..04
      rst = 1'b0; en = 1'b1; vld_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d = 8'(i);
         step();
         if (i == 1) chk_g("fill1", 8'hA5, 1'b0, 3'd1);
      end
      chk_g("fill4", 8'h01, 1'b1, 3'd4);

      // stall: inputs must be ignored
      en = 1'b0; vld_i = 1'b1; d = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_g("stall", 8'h01, 1'b1, 3'd4);
      end

      // drain with vld_i = 0
      en = 1'b1; vld_i = 1'b0; d = 8'h00;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_g("drain", drain_q[i], (i < 3), drain_c[i]);
      end

      // bubbles and output gating
      for (int i = 0; i < 4; i++) begin
         d = 8'h10 + 8'(i);
         vld_i = bub_v[i];
         step();
      end
      d = 8'h00; vld_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_g("bubble", bub_qg[i], bub_v[i], bub_c[i]);
         chk("bubble_raw_q", 32'(q_u), 32'(bub_qu[i]));
         step();
      end

      // flush beats en
      vld_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         d = 8'(i);
         step();
      end
      chk_g("prefl", 8'h01, 1'b1, 3'd4);
      flush = 1'b1; d = 8'hFF; vld_i = 1'b1;
      step();
      flush = 1'b0; vld_i = 1'b0; d = 8'h00;
      chk_g("flush", 8'hA5, 1'b0, 3'd0);
      chk("flush_raw_q", 32'(q_u), 32'hA5);
      for (int i = 0; i < 4; i++) begin
         step();
         chk_g("postfl", 8'hA5, 1'b0, 3'd0);
         chk("postfl_raw_q", 32'(q_u), (i < 3) ? 32'hA5 : 32'h00);
      end

      // mid-stream reset
      vld_i = 1'b1;
      d = 8'h21; step();
      d = 8'h22; step();
      chk("mid_cnt", 32'(cnt_g), 32'd2);
      rst = 1'b1; d = 8'h23; step();
      rst = 1'b0;
      chk_g("midrst", 8'hA5, 1'b0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         d = 8'h31 + 8'(i);
         step();
         if (i < 3) chk_g("restart", 8'hA5, 1'b0, 3'(i + 1));
      end
      chk_g("restart4", 8'h31, 1'b1, 3'd4);
      en = 1'b0;

      // DEPTH=1, WIDTH=1 against a reference model
      m_q = 1'b1; m_v = 1'b0; m_cnt = 1'b0;
      r1_rst = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         r1_en    = 1'($urandom_range(0, 3) != 0);
         r1_vld_i = 1'($urandom_range(0, 1));
         r1_d     = 1'($urandom_range(0, 1));
         r1_flush = 1'($urandom_range(0, 15) == 0);
         r1_rst   = 1'($urandom_range(0, 31) == 0);
         @(posedge clk);
         if (r1_rst || r1_flush) begin
            m_q = 1'b1; m_v = 1'b0; m_cnt = 1'b0;
         end else if (r1_en) begin
            m_cnt = m_cnt + r1_vld_i - m_v;
            m_q = r1_d; m_v = r1_vld_i;
         end
         #1;
         m_qexp = m_v ? m_q : 1'b1;
         chk("d1_q",   32'(q_1),   32'(m_qexp));
         chk("d1_vld", 32'(vo_1),  32'(m_v));
         chk("d1_cnt", 32'(cnt_1), 32'(m_cnt));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_dff_pipe.md
# sync_dff_pipe

Parametrised register pipeline with a per-stage valid bit, stall enable, synchronous flush and an occupancy counter. It generalises the single reset flop into a DEPTH-stage, WIDTH-bit delay line with programmable reset value and optional output gating. It sits between blocks that need a fixed, stallable latency, such as retiming, alignment of parallel datapaths or delay matching.

## Interface
Parameters:
- WIDTH, 8: data width in bits, at least 1.
- DEPTH, 4: number of register stages, at least 1.
- RST_VAL, 0: WIDTH-bit value loaded into every data stage on reset and on flush.
- GATE_Q, 1: if 1, `q` shows RST_VAL whenever `vld_o` is 0. If 0, `q` is the raw last-stage data.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- en  in  1  shift enable. 0 holds all stages.
- flush  in  1  synchronous clear of all stages and the counter.
- d  in  WIDTH  input data.
- vld_i  in  1  input data valid.
- q  out  WIDTH  last-stage data.
- vld_o  out  1  last-stage valid.
- cnt  out  $clog2(DEPTH+1)  number of stages currently holding valid data.

## Operation
- Stage state: data[k] and vld[k], for k = 0..DEPTH-1. Stage 0 is the input side. Stage DEPTH-1 drives `q` and `vld_o`.
- Priority per rising edge: rst > flush > en > hold.
- rst = 1:
  - all data[k] become RST_VAL.
  - all vld[k] become 0.
  - cnt becomes 0.
- flush = 1 (with rst = 0):
  - same effect as rst, regardless of en, d and vld_i.
  - the word presented on that cycle is discarded.
- en = 1:
  - data[0] takes d and vld[0] takes vld_i.
  - data[k] takes data[k-1] and vld[k] takes vld[k-1], for k ≥ 1.
  - d is captured even when vld_i = 0. Only the valid bit qualifies it.
- en = 0: all state holds, and vld_i is ignored.
- Counter:
  - cnt is registered and updated incrementally. It does not re-sum the valid bits.
  - on en = 1: cnt ← cnt + vld_i − vld[DEPTH-1]. Increment and decrement in the same cycle cancel.
  - on en = 0: cnt holds.
  - range is 0..DEPTH. Overflow and underflow cannot occur by construction.
  - cnt must always equal the number of set vld[k]. Verification asserts this every cycle.
- Output:
  - GATE_Q = 1: q = vld_o ? data[DEPTH-1] : RST_VAL. This is combinational from registered state only.
  - GATE_Q = 0: q = data[DEPTH-1].
- No combinational path from any input to any output.

## Timing
- Reset values:
  - q = RST_VAL.
  - vld_o = 0.
  - cnt = 0.
- Latency:
  - a word presented with en = 1 at edge N appears on q/vld_o after edge N+DEPTH-1, when en stays high throughout.
  - each en = 0 cycle adds one cycle of latency.
- DEPTH = 1: q/vld_o are visible the cycle after capture.
- Throughput: one word per en-high cycle. No bubbles are inserted.
- Simultaneous flush and en: flush wins, and all stages are empty after the edge.
- rst asserted mid-stream: all data is lost and the outputs return to reset values after that edge.
- rst released: the first capture happens at the first edge with rst = 0, flush = 0 and en = 1.

## Structure
- Package sync_dff_pipe_pkg:
  - function cnt_w(depth) returning $clog2(depth+1).
  - no other shared typedefs are required.
- Sub-module dff_stage:
  - one WIDTH-bit register plus valid bit.
  - inputs: clk, rst, clr (flush), en, d, vld_i.
  - parameterised by WIDTH and RST_VAL.
- sync_dff_pipe builds the chain of DEPTH dff_stage instances with a generate loop. It also holds the counter and the output gating.

## Test plan
- Reset and fill (WIDTH = 8, DEPTH = 4, RST_VAL = 8'hA5, GATE_Q = 1):
  - hold rst for 3 cycles → q = A5, vld_o = 0, cnt = 0.
  - release rst, then en = 1, vld_i = 1, d = 01, 02, 03, 04 → after the 4th edge q = 01, vld_o = 1, cnt = 4.
- Stall:
  - with the pipe full of 01..04, drop en for 5 cycles → q stays 01, cnt stays 4.
  - re-assert en with vld_i = 0 → q steps 02, 03, 04, A5 and cnt counts 4, 3, 2, 1, 0.
- Bubbles and gating:
  - stream d = 10, 11, 12, 13 with vld_i = 1, 0, 1, 0 → vld_o sequence is 1, 0, 1, 0 and q is 10, A5, 12, A5.
  - repeat with GATE_Q = 0 → q is 10, 11, 12, 13.
- Flush versus en:
  - pipe full, assert flush with en = 1, vld_i = 1, d = FF for one cycle → next cycle all stages are empty, cnt = 0, q = A5.
  - the FF word never appears on q.
- Mid-stream reset:
  - after 2 of 4 valid words, pulse rst for one cycle while en = 1 → outputs return to reset values.
  - subsequent words arrive with full DEPTH latency, and cnt restarts from 0.
- DEPTH = 1, WIDTH = 1:
  - random en/vld_i/d/flush for 1000 cycles → a scoreboard model matches q, vld_o and cnt every cycle.
